// File: rtl/nec_key_decoder.sv
// NEC key decoder: validates raw receiver frames and tracks press/hold/release of a key.
// Define NEC_KEY_AUTOREPEAT_EN to enable typematic auto-repeat events while a key is held.
module nec_key_decoder #(
  parameter int CLK_PER_MS        = 50000,
  parameter int REPEAT_TIMEOUT_MS = 120,
  parameter int AUTO_DELAY_MS     = 500,
  parameter int AUTO_RATE_MS      = 200,
  parameter int STRICT_ADDR       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [31:0] frame_data,
  input  logic        repeat_valid,
  output logic        key_valid,
  output logic [7:0]  key_cmd,
  output logic [15:0] key_addr,
  output logic        key_repeat,
  output logic        key_held,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int TO_W  = $clog2(REPEAT_TIMEOUT_MS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(REPEAT_TIMEOUT_MS);

`ifdef NEC_KEY_AUTOREPEAT_EN
  localparam int AU_MAX = (AUTO_DELAY_MS > AUTO_RATE_MS) ? AUTO_DELAY_MS : AUTO_RATE_MS;
  localparam int AU_W   = $clog2(AU_MAX + 1);
  localparam logic [AU_W-1:0] AU_DELAY = AU_W'(AUTO_DELAY_MS);
  localparam logic [AU_W-1:0] AU_RATE  = AU_W'(AUTO_RATE_MS);
`endif

  typedef enum logic {IDLE, HELD} state_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0: byte decode and frame validation straight off the receiver bus
  logic [7:0] addr_p0, addr_n_p0, cmd_p0, cmd_n_p0;
  logic       good_p0;

  assign addr_p0   = bitrev8(frame_data[31:24]);
  assign addr_n_p0 = bitrev8(frame_data[23:16]);
  assign cmd_p0    = bitrev8(frame_data[15:8]);
  assign cmd_n_p0  = bitrev8(frame_data[7:0]);
  assign good_p0   = (cmd_p0 == ~cmd_n_p0) &&
                     ((STRICT_ADDR == 0) || (addr_p0 == ~addr_n_p0));

  // Millisecond prescaler; restarted by key activity so timeouts run from the event
  logic [PRE_W-1:0] ms_cnt_q;
  logic             ms_tick;
  logic             pre_clr;

  assign ms_tick = (ms_cnt_q == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ms_cnt_q <= '0;
    end else if (pre_clr || ms_tick) begin
      ms_cnt_q <= '0;
    end else begin
      ms_cnt_q <= ms_cnt_q + PRE_W'(1);
    end
  end

  // Stage p1: state, counters and registered key outputs
  state_t          state_q, state_d;
  logic [TO_W-1:0] timeout_q, timeout_d;
  logic            vld_p1, vld_d;
  logic            err_p1, err_d;
  logic [7:0]      cmd_p1, cmd_d;
  logic [15:0]     addr_p1, addr_d;
  logic [7:0]      errc_p1, errc_d;
`ifdef NEC_KEY_AUTOREPEAT_EN
  logic [AU_W-1:0] auto_q, auto_d;
  logic            rpt_p1, rpt_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timeout_q <= '0;
      vld_p1    <= 1'b0;
      err_p1    <= 1'b0;
      cmd_p1    <= '0;
      addr_p1   <= '0;
      errc_p1   <= '0;
`ifdef NEC_KEY_AUTOREPEAT_EN
      auto_q    <= '0;
      rpt_p1    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      vld_p1    <= vld_d;
      err_p1    <= err_d;
      cmd_p1    <= cmd_d;
      addr_p1   <= addr_d;
      errc_p1   <= errc_d;
`ifdef NEC_KEY_AUTOREPEAT_EN
      auto_q    <= auto_d;
      rpt_p1    <= rpt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    cmd_d     = cmd_p1;
    addr_d    = addr_p1;
    errc_d    = errc_p1;
    pre_clr   = 1'b0;
`ifdef NEC_KEY_AUTOREPEAT_EN
    auto_d    = auto_q;
    rpt_d     = 1'b0;
`endif
    // A frame outranks a same-cycle repeat strobe in every state
    if (frame_valid) begin
      if (good_p0) begin
        state_d   = HELD;
        vld_d     = 1'b1;
        cmd_d     = cmd_p0;
        addr_d    = {addr_n_p0, addr_p0};
        timeout_d = TO_LOAD;
        pre_clr   = 1'b1;
`ifdef NEC_KEY_AUTOREPEAT_EN
        auto_d    = AU_DELAY;
`endif
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
        errc_d  = sat_inc8(errc_p1);
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        HELD: begin
          if (repeat_valid) begin
            timeout_d = TO_LOAD;
            pre_clr   = 1'b1;
          end else if (ms_tick) begin
            if (timeout_q <= TO_W'(1)) begin
              state_d = IDLE;
            end else begin
              timeout_d = timeout_q - TO_W'(1);
            end
          end
`ifdef NEC_KEY_AUTOREPEAT_EN
          // Auto-repeat timing is anchored to the press, so repeats do not reload it
          if (ms_tick && (state_d == HELD)) begin
            if (auto_q <= AU_W'(1)) begin
              vld_d  = 1'b1;
              rpt_d  = 1'b1;
              auto_d = AU_RATE;
            end else begin
              auto_d = auto_q - AU_W'(1);
            end
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign key_valid = vld_p1;
  assign key_cmd   = cmd_p1;
  assign key_addr  = addr_p1;
  assign key_held  = (state_q == HELD);
  assign frame_err = err_p1;
  assign err_count = errc_p1;
`ifdef NEC_KEY_AUTOREPEAT_EN
  assign key_repeat = rpt_p1;
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: doc/nec_key_decoder.md
Name: nec_key_decoder

Overview:
- Sits directly downstream of the NEC IR receiver and consumes its raw 32-bit frames and repeat-code strobes.
- Decodes and validates each frame, and tracks the press/hold/release lifetime of a key.
- Produces one-cycle key events, with optional typematic auto-repeat, for the display and control logic.
- Clock is 50 MHz in the system. All timing is derived from a millisecond prescaler.

Parameters:
- CLK_PER_MS, 50000: clk cycles per 1 ms tick.
- REPEAT_TIMEOUT_MS, 120: release a held key if no repeat or frame arrives within this time.
- AUTO_DELAY_MS, 500: hold time before the first auto-repeat event.
- AUTO_RATE_MS, 200: interval between subsequent auto-repeat events.
- STRICT_ADDR, 1: 1 = require addr == ~addr_n; 0 = extended 16-bit address, with no address check.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low; clock clk
- frame_valid  in  1  one-cycle strobe; frame_data is valid in the same cycle
- frame_data  in  32  raw frame, first-received bit in bit 31
- repeat_valid  in  1  one-cycle strobe for an NEC repeat code (9 ms + 2.25 ms leader)
- key_valid  out  1  one-cycle key event
- key_cmd  out  8  decoded command; held stable between events
- key_addr  out  16  {addr_n, addr}, decoded
- key_repeat  out  1  qualifies key_valid: 0 = new press, 1 = auto-repeat
- key_held  out  1  level, high while a key is considered pressed
- frame_err  out  1  one-cycle pulse on a rejected frame
- err_count  out  8  count of rejected frames, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Byte decode: the receiver emits each byte bit-reversed (NEC sends LSB first).
  - addr = bitrev(frame_data[31:24])
  - addr_n = bitrev(frame_data[23:16])
  - cmd = bitrev(frame_data[15:8])
  - cmd_n = bitrev(frame_data[7:0])
- Frame is good when cmd == ~cmd_n, and additionally addr == ~addr_n if STRICT_ADDR=1.
- Latency: frame_valid sampled in cycle N gives key_valid / frame_err registered high in cycle N+1.
  - key_cmd / key_addr update in the same cycle as key_valid.
- Millisecond tick:
  - Prescaler counts 0..CLK_PER_MS-1 and emits a tick on wrap.
  - Prescaler is cleared on every accepted frame and every accepted repeat_valid, so timing is measured from the event.
- State machine:
  - IDLE:
    - Good frame: key_valid=1, key_repeat=0, key_held=1; load timeout = REPEAT_TIMEOUT_MS and auto = AUTO_DELAY_MS; go to HELD.
    - Bad frame: frame_err=1, err_count+1; stay in IDLE.
    - repeat_valid: ignored (orphan repeat), no output.
  - HELD:
    - repeat_valid: reload timeout; auto counter is not reloaded.
    - Good frame: treated as a new press (any cmd, including the same one); same actions as from IDLE.
    - Bad frame: frame_err=1, err_count+1, key_held=0; go to IDLE.
    - Timeout reaches 0 on a tick: key_held=0; go to IDLE, no key_valid.
    - Auto-repeat: see Optional Feature.
- Simultaneous frame_valid and repeat_valid: frame_valid wins and repeat_valid is dropped.
- Timeout expiry coinciding with repeat_valid: the repeat wins; key stays HELD.
- err_count saturates at 255. It is cleared only by reset.
- Reset mid-hold: immediate return to the reset state on the next clk edge; no release event is emitted.

Optional Feature:
- Macro: NEC_KEY_AUTOREPEAT_EN.
- Defined:
  - In HELD, the auto counter decrements on each tick.
  - On reaching 0: key_valid=1, key_repeat=1, key_cmd/key_addr unchanged; reload auto = AUTO_RATE_MS.
  - Events continue until release.
- Undefined:
  - Auto counter is absent and key_repeat is tied to 0.
  - Only the initial press produces key_valid; repeats only extend key_held.

Test Plan (CLK_PER_MS=10, defaults otherwise):
- frame_data=0x00FF6897 strobed -> next cycle key_valid=1, key_cmd=0x16, key_addr=0xFF00, key_repeat=0, key_held=1.
- frame_data=0x00FF6896 -> frame_err pulse, err_count=1, key_valid stays 0, key_held=0.
- Good frame, then repeat_valid every 1080 cycles for 5 repeats -> key_held stays 1. It drops exactly 1200 cycles (+1 latency) after the last repeat.
- repeat_valid while IDLE -> no outputs change. frame_valid and repeat_valid in the same cycle with a good frame -> single key_valid, timeout loaded from the frame.
- With NEC_KEY_AUTOREPEAT_EN, frame held by repeats -> key_repeat=1 events at about 5000 cycles after the press, then every 2000 cycles. Without the macro -> no further events.
- 260 bad frames -> err_count holds 255. STRICT_ADDR=0 with frame 0x00006897 -> accepted, key_addr=0x0000.
